// File: rtl/case3_pkg.sv
// Shared constants, scheduler state type and the case3 reference function
// used by both the evaluator datapath and the bench model.
package case3_pkg;

  localparam int VEC_W   = 7;
  localparam int OUT_W   = 3;
  localparam int NUM_VEC = 128;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_t;

  // vec = {a,b,c,d,e,f,g}; returns {x,y,z}
  function automatic logic [OUT_W-1:0] case3_f(input logic [VEC_W-1:0] vec);
    logic a, b, c, d, e, f, g;
    {a, b, c, d, e, f, g} = vec;
    return {a & b & c & d & e,
            b | c | (b ^ d ^ f) | (d ^ e ^ f ^ g),
            c ^ d ^ (c & e & g) ^ (a & b & e & g)};
  endfunction

endpackage

// File: rtl/case3_rr_arb.sv
// Round-robin arbiter: picks the first asserted request scanning upward from
// i_ptr with wrap-around; grant is one-hot or all zero.
module case3_rr_arb #(
  parameter  int N_REQ = 4,
  localparam int PTR_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [N_REQ-1:0] o_grant
);

  logic w_hit;

  always_comb begin
    o_grant = '0;
    w_hit   = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (!w_hit && i_req[i] && (((int'(i_ptr) + k) % N_REQ) == i)) begin
          o_grant[i] = 1'b1;
          w_hit      = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/case3_eval_sched.sv
// Shares one case3 evaluator among N_REQ valid/ready requesters with a
// registered response slot, and runs a 128-vector self-test sweep on request.
module case3_eval_sched
  import case3_pkg::*;
#(
  parameter  int N_REQ = 4,
  parameter  int SIG_W = 16,
  localparam int ID_W  = $clog2(N_REQ)
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [N_REQ-1:0]         i_req_valid,
  input  logic [VEC_W*N_REQ-1:0]   i_req_vec,
  output logic [N_REQ-1:0]         o_req_ready,
  output logic                     o_rsp_valid,
  input  logic                     i_rsp_ready,
  output logic [ID_W-1:0]          o_rsp_id,
  output logic [OUT_W-1:0]         o_rsp_xyz,
  input  logic                     i_sweep_start,
  output logic                     o_sweep_busy,
  output logic                     o_sweep_done,
  output logic [SIG_W-1:0]         o_sweep_sig,
  output logic [7:0]               o_cnt_x,
  output logic [7:0]               o_cnt_y,
  output logic [7:0]               o_cnt_z
);

  state_t            r_state;
  state_t            w_state_next;
  logic              r_pend;
  logic [ID_W-1:0]   r_rr_ptr;
  logic              r_rsp_valid;
  logic [ID_W-1:0]   r_rsp_id;
  logic [OUT_W-1:0]  r_rsp_xyz;
  logic [VEC_W-1:0]  r_idx;
  logic [SIG_W-1:0]  r_sig;
  logic [7:0]        r_cnt_x;
  logic [7:0]        r_cnt_y;
  logic [7:0]        r_cnt_z;
  logic              r_done;

  logic              w_slot_free;
  logic              w_grant_en;
  logic              w_busy;
  logic              w_accept;
  logic              w_sweep_last;
  logic              w_sweep_enter;
  logic [N_REQ-1:0]  w_grant;
  logic [N_REQ-1:0]  w_req_ready;
  logic [VEC_W-1:0]  w_req_vec;
  logic [VEC_W-1:0]  w_eval_vec;
  logic [ID_W-1:0]   w_grant_id;
  logic [OUT_W-1:0]  w_xyz;

  assign w_slot_free   = !r_rsp_valid || i_rsp_ready;
  assign w_sweep_last  = (r_state == SWEEP) && (r_idx == VEC_W'(NUM_VEC - 1));
  assign w_sweep_enter = (r_state == IDLE) && (w_state_next == SWEEP);

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  // The sweep waits for the response slot to drain before taking the evaluator
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (r_pend && !r_rsp_valid) w_state_next = SWEEP;
      SWEEP:   if (w_sweep_last)           w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    w_busy     = 1'b0;
    w_grant_en = 1'b0;
    case (r_state)
      IDLE:    w_grant_en = !r_pend && !i_sweep_start;
      SWEEP:   w_busy     = 1'b1;
      default: ;
    endcase
  end

  case3_rr_arb #(
    .N_REQ (N_REQ)
  ) u_arb (
    .i_req   (i_req_valid),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_grant)
  );

  assign w_req_ready = w_grant & {N_REQ{w_grant_en && w_slot_free}};
  assign w_accept    = |w_req_ready;

  always_comb begin
    w_req_vec  = '0;
    w_grant_id = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_grant[i]) begin
        w_req_vec  = i_req_vec[VEC_W*i +: VEC_W];
        w_grant_id = ID_W'(i);
      end
    end
  end

  // Single evaluator instance shared between the sweep index and the granted vector
  assign w_eval_vec = w_busy ? r_idx : w_req_vec;
  assign w_xyz      = case3_f(w_eval_vec);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_xyz   <= '0;
      r_rr_ptr    <= '0;
    end else if (w_accept) begin
      r_rsp_valid <= 1'b1;
      r_rsp_id    <= w_grant_id;
      r_rsp_xyz   <= w_xyz;
      r_rr_ptr    <= (w_grant_id == ID_W'(N_REQ - 1)) ? '0 : w_grant_id + 1'b1;
    end else if (i_rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst)                                  r_pend <= 1'b0;
    else if (w_sweep_last)                      r_pend <= 1'b0;
    else if (i_sweep_start && r_state != SWEEP) r_pend <= 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_idx   <= '0;
      r_sig   <= '0;
      r_cnt_x <= '0;
      r_cnt_y <= '0;
      r_cnt_z <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= w_sweep_last;
      if (w_sweep_enter) begin
        r_idx   <= '0;
        r_sig   <= '0;
        r_cnt_x <= '0;
        r_cnt_y <= '0;
        r_cnt_z <= '0;
      end else if (w_busy) begin
        r_idx   <= r_idx + 1'b1;
        r_sig   <= {r_sig[SIG_W-2:0], r_sig[SIG_W-1]} ^ {{(SIG_W-OUT_W){1'b0}}, w_xyz};
        r_cnt_x <= r_cnt_x + {7'b0, w_xyz[2]};
        r_cnt_y <= r_cnt_y + {7'b0, w_xyz[1]};
        r_cnt_z <= r_cnt_z + {7'b0, w_xyz[0]};
      end
    end
  end

  assign o_req_ready  = w_req_ready;
  assign o_rsp_valid  = r_rsp_valid;
  assign o_rsp_id     = r_rsp_id;
  assign o_rsp_xyz    = r_rsp_xyz;
  assign o_sweep_busy = w_busy;
  assign o_sweep_done = r_done;
  assign o_sweep_sig  = r_sig;
  assign o_cnt_x      = r_cnt_x;
  assign o_cnt_y      = r_cnt_y;
  assign o_cnt_z      = r_cnt_z;

endmodule

// File: tb/tb_case3_eval_sched.sv
// Directed bench for case3_eval_sched: vector table through the request path,
// round-robin/backpressure sequence, sweep timing/results, and reset mid-sweep.
module tb_case3_eval_sched;
  import case3_pkg::*;

  localparam int N_REQ = 4;
  localparam int SIG_W = 16;

  logic                   clk;
  logic                   rst;
  logic [N_REQ-1:0]       req_valid;
  logic [7*N_REQ-1:0]     req_vec;
  logic [N_REQ-1:0]       req_ready;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [1:0]             rsp_id;
  logic [2:0]             rsp_xyz;
  logic                   sweep_start;
  logic                   busy;
  logic                   done;
  logic [SIG_W-1:0]       sig;
  logic [7:0]             cnt_x;
  logic [7:0]             cnt_y;
  logic [7:0]             cnt_z;

  case3_eval_sched #(
    .N_REQ (N_REQ),
    .SIG_W (SIG_W)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_req_valid   (req_valid),
    .i_req_vec     (req_vec),
    .o_req_ready   (req_ready),
    .o_rsp_valid   (rsp_valid),
    .i_rsp_ready   (rsp_ready),
    .o_rsp_id      (rsp_id),
    .o_rsp_xyz     (rsp_xyz),
    .i_sweep_start (sweep_start),
    .o_sweep_busy  (busy),
    .o_sweep_done  (done),
    .o_sweep_sig   (sig),
    .o_cnt_x       (cnt_x),
    .o_cnt_y       (cnt_y),
    .o_cnt_z       (cnt_z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    int         req;
    logic [6:0] vec;
    logic [2:0] xyz;
  } vec_rec_t;

  vec_rec_t    tbl[12];
  int          n_checks = 0;
  int          n_errs   = 0;
  int          exp_ptr;
  logic [15:0] gold_sig;
  logic [2:0]  rr_xyz[4];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", name, got, exp);
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_rsp_valid"}, {31'b0, rsp_valid}, 0);
    chk({tag, "_rsp_id"},    {30'b0, rsp_id},    0);
    chk({tag, "_rsp_xyz"},   {29'b0, rsp_xyz},   0);
    chk({tag, "_req_ready"}, {28'b0, req_ready}, 0);
    chk({tag, "_busy"},      {31'b0, busy},      0);
    chk({tag, "_done"},      {31'b0, done},      0);
    chk({tag, "_sig"},       {16'b0, sig},       0);
    chk({tag, "_cnt_x"},     {24'b0, cnt_x},     0);
    chk({tag, "_cnt_y"},     {24'b0, cnt_y},     0);
    chk({tag, "_cnt_z"},     {24'b0, cnt_z},     0);
  endtask

  // Returns at the negedge where done is seen; done_at counts negedges from 1
  task automatic wait_sweep(output int done_at, output int busy_cyc, output int leaks);
    done_at  = -1;
    busy_cyc = 0;
    leaks    = 0;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      if (busy) busy_cyc++;
      if (busy && req_ready != '0) leaks++;
      if (done) begin
        done_at = k;
        break;
      end
    end
  endtask

  task automatic run_full_sweep(input string tag);
    int done_at, busy_cyc, leaks;
    @(negedge clk);
    sweep_start = 1'b1;
    @(negedge clk);
    sweep_start = 1'b0;
    chk({tag, "_busy_pending"}, {31'b0, busy}, 0);
    wait_sweep(done_at, busy_cyc, leaks);
    chk({tag, "_done_cycle"},  done_at,  129);
    chk({tag, "_busy_cycles"}, busy_cyc, 128);
    chk({tag, "_cnt_x"}, {24'b0, cnt_x}, 4);
    chk({tag, "_cnt_y"}, {24'b0, cnt_y}, 120);
    chk({tag, "_cnt_z"}, {24'b0, cnt_z}, 64);
    chk({tag, "_sig"},   {16'b0, sig},   {16'b0, gold_sig});
    $display("sweep %s: done_at=%0d busy=%0d cnt=%0d/%0d/%0d sig=%h",
             tag, done_at, busy_cyc, cnt_x, cnt_y, cnt_z, sig);
    @(negedge clk);
    chk({tag, "_done_pulse_end"}, {31'b0, done}, 0);
    chk({tag, "_sig_held"}, {16'b0, sig}, {16'b0, gold_sig});
  endtask

  initial begin
    logic [2:0] gxyz;
    int done_at, busy_cyc, leaks, held_id;

    tbl[0]  = '{0, 7'h7F, 3'b110};
    tbl[1]  = '{0, 7'h00, 3'b000};
    tbl[2]  = '{0, 7'h20, 3'b010};
    tbl[3]  = '{3, 7'h10, 3'b011};
    tbl[4]  = '{1, 7'h08, 3'b011};
    tbl[5]  = '{2, 7'h0A, 3'b001};
    tbl[6]  = '{1, 7'h40, 3'b000};
    tbl[7]  = '{2, 7'h7C, 3'b110};
    tbl[8]  = '{3, 7'h01, 3'b010};
    tbl[9]  = '{0, 7'h15, 3'b010};
    tbl[10] = '{1, 7'h65, 3'b011};
    tbl[11] = '{2, 7'h06, 3'b010};

    gold_sig = '0;
    for (int v = 0; v < 128; v++) begin
      gxyz     = case3_f(7'(v));
      gold_sig = {gold_sig[14:0], gold_sig[15]} ^ {13'b0, gxyz};
    end

    rst         = 1'b1;
    req_valid   = '0;
    req_vec     = '0;
    rsp_ready   = 1'b0;
    sweep_start = 1'b0;
    exp_ptr     = 0;
    repeat (3) @(negedge clk);
    chk_zero_outputs("reset");
    rst = 1'b0;

    // Single-requester vectors, one accept per row
    rsp_ready = 1'b1;
    for (int r = 0; r < 12; r++) begin
      @(negedge clk);
      req_valid = 4'b0001 << tbl[r].req;
      req_vec[7*tbl[r].req +: 7] = tbl[r].vec;
      #1;
      chk($sformatf("row%0d_req_ready", r), {28'b0, req_ready}, {28'b0, 4'b0001 << tbl[r].req});
      @(negedge clk);
      req_valid = '0;
      chk($sformatf("row%0d_rsp_valid", r), {31'b0, rsp_valid}, 1);
      chk($sformatf("row%0d_rsp_id", r),    {30'b0, rsp_id},    tbl[r].req);
      chk($sformatf("row%0d_rsp_xyz", r),   {29'b0, rsp_xyz},   {29'b0, tbl[r].xyz});
      $display("row %0d: req=%0d vec=%h xyz=%b id=%0d", r, tbl[r].req, tbl[r].vec, rsp_xyz, rsp_id);
      exp_ptr = (tbl[r].req + 1) % N_REQ;
    end

    // All requesters valid: round-robin order, then backpressure
    @(negedge clk);
    rr_xyz[0] = 3'b110;  req_vec[6:0]   = 7'h7F;
    rr_xyz[1] = 3'b001;  req_vec[13:7]  = 7'h0A;
    rr_xyz[2] = 3'b011;  req_vec[20:14] = 7'h65;
    rr_xyz[3] = 3'b011;  req_vec[27:21] = 7'h10;
    req_valid = 4'b1111;
    for (int n = 0; n < 8; n++) begin
      #1;
      chk($sformatf("rr%0d_grant", n), {28'b0, req_ready}, {28'b0, 4'b0001 << exp_ptr});
      @(negedge clk);
      chk($sformatf("rr%0d_rsp_id", n),  {30'b0, rsp_id},  exp_ptr);
      chk($sformatf("rr%0d_rsp_xyz", n), {29'b0, rsp_xyz}, {29'b0, rr_xyz[exp_ptr]});
      $display("rr %0d: grant=%0d xyz=%b", n, rsp_id, rsp_xyz);
      exp_ptr = (exp_ptr + 1) % N_REQ;
    end
    rsp_ready = 1'b0;
    held_id   = (exp_ptr + N_REQ - 1) % N_REQ;
    for (int n = 0; n < 5; n++) begin
      #1;
      chk($sformatf("bp%0d_req_ready", n), {28'b0, req_ready}, 0);
      chk($sformatf("bp%0d_rsp_valid", n), {31'b0, rsp_valid}, 1);
      chk($sformatf("bp%0d_rsp_id", n),    {30'b0, rsp_id},    held_id);
      chk($sformatf("bp%0d_rsp_xyz", n),   {29'b0, rsp_xyz},   {29'b0, rr_xyz[held_id]});
      @(negedge clk);
    end
    $display("backpressure: held id=%0d xyz=%b", rsp_id, rsp_xyz);
    req_valid = '0;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("drain_rsp_valid", {31'b0, rsp_valid}, 0);

    run_full_sweep("sweep1");

    // Sweep requested while the response slot is full
    @(negedge clk);
    req_valid = 4'b0001;
    req_vec[6:0] = 7'h7F;
    rsp_ready = 1'b0;
    #1;
    chk("s5_first_grant", {28'b0, req_ready}, 1);
    @(negedge clk);
    req_valid = 4'b0010;
    req_vec[13:7] = 7'h0A;
    sweep_start = 1'b1;
    #1;
    chk("s5_rsp_valid", {31'b0, rsp_valid}, 1);
    chk("s5_no_grant_start", {28'b0, req_ready}, 0);
    @(negedge clk);
    sweep_start = 1'b0;
    chk("s5_busy_wait", {31'b0, busy}, 0);
    chk("s5_no_grant_pend", {28'b0, req_ready}, 0);
    @(negedge clk);
    chk("s5_rsp_held", {29'b0, rsp_xyz}, {29'b0, 3'b110});
    rsp_ready = 1'b1;
    #1;
    chk("s5_no_grant_free", {28'b0, req_ready}, 0);
    @(negedge clk);
    chk("s5_drained", {31'b0, rsp_valid}, 0);
    chk("s5_busy_not_yet", {31'b0, busy}, 0);
    chk("s5_no_grant_drained", {28'b0, req_ready}, 0);
    @(negedge clk);
    chk("s5_busy_started", {31'b0, busy}, 1);
    wait_sweep(done_at, busy_cyc, leaks);
    chk("s5_done_cycle", done_at, 128);
    chk("s5_grant_leaks", leaks, 0);
    chk("s5_cnt_y", {24'b0, cnt_y}, 120);
    chk("s5_sig", {16'b0, sig}, {16'b0, gold_sig});
    #1;
    chk("s5_grant_after_done", {28'b0, req_ready}, 2);
    @(negedge clk);
    req_valid = '0;
    chk("s5_rsp_valid_after", {31'b0, rsp_valid}, 1);
    chk("s5_rsp_id_after", {30'b0, rsp_id}, 1);
    chk("s5_rsp_xyz_after", {29'b0, rsp_xyz}, {29'b0, 3'b001});
    $display("s5: post-sweep accept id=%0d xyz=%b", rsp_id, rsp_xyz);

    // Reset at sweep index 60, then a clean rerun
    @(negedge clk);
    sweep_start = 1'b1;
    @(negedge clk);
    sweep_start = 1'b0;
    for (int k = 0; k < 10 && !busy; k++) @(negedge clk);
    chk("s6_busy_seen", {31'b0, busy}, 1);
    repeat (60) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_zero_outputs("s6_rst");
    $display("s6: reset mid-sweep sig=%h busy=%0d", sig, busy);
    rst = 1'b0;
    run_full_sweep("sweep2");

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
